// File: rtl/vga_pkg.sv
// Screen extents and PS/2 mouse header-byte field positions shared by the
// display and pointer logic.
package vga_pkg;

   localparam int SCREEN_W = 1024;
   localparam int SCREEN_H = 768;
   localparam int POS_W    = 12;

   // Bit positions inside the first byte of a PS/2 mouse packet.
   localparam int B0_LEFT   = 0;
   localparam int B0_RIGHT  = 1;
   localparam int B0_MIDDLE = 2;
   localparam int B0_SYNC   = 3;
   localparam int B0_XSIGN  = 4;
   localparam int B0_YSIGN  = 5;
   localparam int B0_XOVF   = 6;
   localparam int B0_YOVF   = 7;

   typedef struct packed {
      logic       middle;
      logic       right;
      logic       left;
      logic       x_sign;
      logic       y_sign;
      logic       x_ovf;
      logic       y_ovf;
   } hdr_t;

endpackage

// File: rtl/mouse_axis_accum.sv
// One cursor axis: sign-extends a 9-bit PS/2 delta, applies it to the current
// position and clamps the result to 0..MAX, holding position on overflow.
module mouse_axis_accum
   import vga_pkg::*;
#(
   parameter int MAX    = SCREEN_W - 1,
   parameter bit INVERT = 1'b0
) (
   input  logic [POS_W-1:0] pos,
   input  logic             sign,
   input  logic [7:0]       mag,
   input  logic             ovf,
   output logic [POS_W-1:0] next_pos
);

   localparam logic signed [13:0] MAX_S = 14'(MAX);

   logic signed [13:0] delta;
   logic signed [13:0] sum;

   // INVERT subtracts the delta, turning PS/2 up-positive motion into screen down-positive.
   always_comb begin
      delta = {{5{sign}}, sign, mag};
      if (INVERT) begin
         sum = $signed({2'b00, pos}) - delta;
      end else begin
         sum = $signed({2'b00, pos}) + delta;
      end
      next_pos = pos;
      if (!ovf) begin
         if (sum < 0) begin
            next_pos = '0;
         end else if (sum > MAX_S) begin
            next_pos = POS_W'(MAX);
         end else begin
            next_pos = POS_W'(sum);
         end
      end
   end

endmodule

// File: rtl/mouse_packet_decoder.sv
// Assembles 3-byte PS/2 mouse packets into an absolute, screen-clamped cursor
// position and button levels, resynchronising on bad bytes and stalls.
module mouse_packet_decoder
   import vga_pkg::*;
#(
   parameter int X_MAX   = SCREEN_W - 1,
   parameter int Y_MAX   = SCREEN_H - 1,
   parameter int X_INIT  = 512,
   parameter int Y_INIT  = 384,
   parameter int TIMEOUT = 100_000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       rx_data,
   input  logic             rx_valid,
   input  logic             rx_err,
   output logic             left_mouse,
   output logic             right_mouse,
   output logic             middle_mouse,
   output logic [POS_W-1:0] xpos,
   output logic [POS_W-1:0] ypos,
   output logic             packet_valid,
   output logic             sync_err
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {WAIT_B0, WAIT_B1, WAIT_B2, UPDATE} state_t;

   state_t           state_q, state_d;
   hdr_t             hdr_q, hdr_d;
   logic [7:0]       dx_q, dx_d;
   logic [7:0]       dy_q, dy_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sync_d;
   logic             upd;
   logic [POS_W-1:0] x_next, y_next;

   mouse_axis_accum #(.MAX(X_MAX), .INVERT(1'b0)) u_x_accum (
      .pos      (xpos),
      .sign     (hdr_q.x_sign),
      .mag      (dx_q),
      .ovf      (hdr_q.x_ovf),
      .next_pos (x_next)
   );

   mouse_axis_accum #(.MAX(Y_MAX), .INVERT(1'b1)) u_y_accum (
      .pos      (ypos),
      .sign     (hdr_q.y_sign),
      .mag      (dy_q),
      .ovf      (hdr_q.y_ovf),
      .next_pos (y_next)
   );

   // UPDATE commits the held packet and also accepts a new header byte in the same cycle.
   always_comb begin
      state_d = state_q;
      hdr_d   = hdr_q;
      dx_d    = dx_q;
      dy_d    = dy_q;
      cnt_d   = '0;
      sync_d  = 1'b0;
      upd     = 1'b0;
      case (state_q)
         WAIT_B0, UPDATE: begin
            upd     = (state_q == UPDATE);
            state_d = WAIT_B0;
            if (rx_err) begin
               sync_d = 1'b1;
            end else if (rx_valid) begin
               if (rx_data[B0_SYNC]) begin
                  hdr_d.left   = rx_data[B0_LEFT];
                  hdr_d.right  = rx_data[B0_RIGHT];
                  hdr_d.middle = rx_data[B0_MIDDLE];
                  hdr_d.x_sign = rx_data[B0_XSIGN];
                  hdr_d.y_sign = rx_data[B0_YSIGN];
                  hdr_d.x_ovf  = rx_data[B0_XOVF];
                  hdr_d.y_ovf  = rx_data[B0_YOVF];
                  state_d      = WAIT_B1;
               end else begin
                  sync_d = 1'b1;
               end
            end
         end
         WAIT_B1, WAIT_B2: begin
            if (rx_err) begin
               sync_d  = 1'b1;
               state_d = WAIT_B0;
            end else if (rx_valid) begin
               if (state_q == WAIT_B1) begin
                  dx_d    = rx_data;
                  state_d = WAIT_B2;
               end else begin
                  dy_d    = rx_data;
                  state_d = UPDATE;
               end
            end else if (cnt_q == CNT_LAST) begin
               sync_d  = 1'b1;
               state_d = WAIT_B0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = WAIT_B0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= WAIT_B0;
         hdr_q   <= '0;
         dx_q    <= '0;
         dy_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         hdr_q   <= hdr_d;
         dx_q    <= dx_d;
         dy_q    <= dy_d;
         cnt_q   <= cnt_d;
      end
   end

   // Visible outputs only move when a whole packet has been collected.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         xpos         <= POS_W'(X_INIT);
         ypos         <= POS_W'(Y_INIT);
         left_mouse   <= 1'b0;
         right_mouse  <= 1'b0;
         middle_mouse <= 1'b0;
         packet_valid <= 1'b0;
         sync_err     <= 1'b0;
      end else begin
         packet_valid <= upd;
         sync_err     <= sync_d;
         if (upd) begin
            xpos         <= x_next;
            ypos         <= y_next;
            left_mouse   <= hdr_q.left;
            right_mouse  <= hdr_q.right;
            middle_mouse <= hdr_q.middle;
         end
      end
   end

endmodule

// File: doc/mouse_packet_decoder.md
Name: mouse_packet_decoder

Overview:
- Decodes the 3-byte PS/2 mouse movement stream into the absolute cursor position and button levels that drive the oscilloscope control logic and the chart-drag logic.
- Sits between the PS/2 byte receiver and the user-interface block.
- Accumulates signed deltas and clamps the result to the visible screen.
- Maps PS/2 Y-up motion to screen Y-down.

Parameters:
- X_MAX, 1023, largest legal xpos (screen width - 1).
- Y_MAX, 767, largest legal ypos (screen height - 1).
- X_INIT, 512, xpos after reset.
- Y_INIT, 384, ypos after reset.
- TIMEOUT, 100_000, maximum clk cycles between bytes of one packet before resync.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- rx_data  in  8  received PS/2 byte.
- rx_valid  in  1  one-cycle strobe: rx_data is valid.
- rx_err  in  1  one-cycle strobe: parity or framing error on the current byte.
- left_mouse  out  1  left button level.
- right_mouse  out  1  right button level.
- middle_mouse  out  1  middle button level.
- xpos  out  12  absolute X, 0..X_MAX.
- ypos  out  12  absolute Y, 0..Y_MAX.
- packet_valid  out  1  one-cycle pulse: outputs updated from a complete packet.
- sync_err  out  1  one-cycle pulse: a byte was discarded or a packet was aborted.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - xpos=X_INIT, ypos=Y_INIT.
  - All three buttons 0; packet_valid=0, sync_err=0.
  - FSM in WAIT_B0; timeout counter and byte holding registers cleared.
- FSM states: WAIT_B0, WAIT_B1, WAIT_B2, UPDATE.
- WAIT_B0:
  - On rx_valid with rx_data[3]=1: latch byte0 and go to WAIT_B1.
  - On rx_valid with rx_data[3]=0: discard the byte, pulse sync_err, stay in WAIT_B0.
- WAIT_B1: on rx_valid, latch dx and go to WAIT_B2.
- WAIT_B2: on rx_valid, latch dy and go to UPDATE.
- UPDATE (single cycle):
  - Register the new xpos, ypos and buttons; pulse packet_valid.
  - Return to WAIT_B0. rx_valid arriving in this cycle is treated as a WAIT_B0 byte.
- Latency: outputs and packet_valid change 2 cycles after the byte2 rx_valid edge, i.e. 1 cycle in UPDATE plus the register stage.
- Byte0 fields:
  - bit0 left, bit1 right, bit2 middle.
  - bit4 X sign, bit5 Y sign.
  - bit6 X overflow, bit7 Y overflow.
- Arithmetic:
  - dx = {Xsign, byte1} as 9-bit two's complement (-256..255); dy likewise.
  - Compute in 14-bit signed.
  - new_x = xpos + dx; new_y = ypos - dy, because PS/2 Y is positive-up.
  - Clamp: result < 0 -> 0; result > MAX -> MAX.
- Overflow: if an axis overflow bit is set, that axis keeps its old value. Buttons and the other axis still update.
- Errors:
  - rx_err in any state aborts the partial packet, pulses sync_err, returns to WAIT_B0.
  - rx_err wins over a simultaneous rx_valid; that byte is discarded.
- Timeout:
  - The counter runs in WAIT_B1 and WAIT_B2 and clears on every accepted byte.
  - On reaching TIMEOUT: abort, pulse sync_err, return to WAIT_B0.
- Buttons change only at packet completion, never mid-packet.
- Reset during a partial packet discards it; no packet_valid is produced.

Decomposition:
- Shared package (vga_pkg): screen extents used for X_MAX/Y_MAX defaults, plus the byte0 bit-index constants.
- Local enum for the FSM states.
- One natural sub-module: mouse_axis_accum, instantiated twice. It does the sign-extend, add/subtract, clamp and overflow hold for one axis.

Test Plan:
- Reset, then send 0x08,0x10,0x00 -> packet_valid once; xpos=528, ypos=384, buttons 0.
- From reset send 0x39,0x00,0x00:
  - byte0 0x39: left=1, X sign set, Y sign set.
  - Expected: left=1, xpos=256, ypos=640.
- Drive xpos to 1020, then send 0x08,0x7F,0x00 -> xpos=1023 (clamped).
- Reset, then send 0x28,0x00,0xFF (dy=-1); repeat 400 times -> ypos stops at 767 and never wraps.
- Send 0x48,0x20,0x05:
  - X overflow set -> xpos unchanged.
  - ypos decreases by 5.
- Sync and error recovery:
  - Send 0x00 -> sync_err pulse, state stays WAIT_B0.
  - Send 0x08,0x04, then idle TIMEOUT cycles -> sync_err pulse.
  - Then send 0x08,0x04,0x00 -> xpos += 4, exactly one packet_valid.
- Assert rst mid-packet after 0x09 -> outputs immediately X_INIT/Y_INIT/0; the next full packet decodes cleanly.
